// File: rtl/jtag_tap_pkg.sv
// Shared TAP controller definitions for the JTAG pin monitor: the 4-bit IEEE 1149.1
// state encoding and the state-transition function.
package jtag_tap_pkg;

    typedef logic [3:0] tap_state_t;

    localparam tap_state_t TAP_TLR   = 4'hF;
    localparam tap_state_t TAP_RTI   = 4'hC;
    localparam tap_state_t TAP_SELDR = 4'h7;
    localparam tap_state_t TAP_CAPDR = 4'h6;
    localparam tap_state_t TAP_SHDR  = 4'h2;
    localparam tap_state_t TAP_EX1DR = 4'h1;
    localparam tap_state_t TAP_PAUDR = 4'h3;
    localparam tap_state_t TAP_EX2DR = 4'h0;
    localparam tap_state_t TAP_UPDDR = 4'h5;
    localparam tap_state_t TAP_SELIR = 4'h4;
    localparam tap_state_t TAP_CAPIR = 4'hE;
    localparam tap_state_t TAP_SHIR  = 4'hA;
    localparam tap_state_t TAP_EX1IR = 4'h9;
    localparam tap_state_t TAP_PAUIR = 4'hB;
    localparam tap_state_t TAP_EX2IR = 4'h8;
    localparam tap_state_t TAP_UPDIR = 4'hD;

    function automatic tap_state_t next_tap(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        nxt = TAP_TLR;
        case (state)
            TAP_TLR:   nxt = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:   nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR: nxt = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR: nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:  nxt = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR: nxt = tms ? TAP_UPDDR : TAP_PAUDR;
            TAP_PAUDR: nxt = tms ? TAP_EX2DR : TAP_PAUDR;
            TAP_EX2DR: nxt = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR: nxt = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR: nxt = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR: nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:  nxt = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR: nxt = tms ? TAP_UPDIR : TAP_PAUIR;
            TAP_PAUIR: nxt = tms ? TAP_EX2IR : TAP_PAUIR;
            TAP_EX2IR: nxt = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR: nxt = tms ? TAP_SELDR : TAP_RTI;
            default:   nxt = TAP_TLR;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_sync2.sv
// Two-flop synchronizer with asynchronous active-high reset, used for each raw JTAG net.
module jtag_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/jtag_tap_monitor.sv
// Passive JTAG TAP mirror: tracks TAP state, last IR, Shift-DR bit count and TCK activity.
// Define JTAG_TAP_MON_TDO_CAPTURE_EN to also capture the last 32 TDO bits of each DR scan.
module jtag_tap_monitor
    import jtag_tap_pkg::*;
#(
    parameter int                 IR_LEN   = 4,
    parameter logic [IR_LEN-1:0]  IR_RESET = IR_LEN'(1),
    parameter int                 ACT_HOLD = 2400000
) (
    input  logic              int_osc,
    input  logic              rst,
    input  logic              tck,
    input  logic              tms,
    input  logic              tdi,
    input  logic              tdo,
    output logic [3:0]        tap_state,
    output logic [IR_LEN-1:0] ir_value,
    output logic              ir_valid,
    output logic [15:0]       dr_bit_count,
`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
    output logic [31:0]       dr_tdo,
`endif
    output logic              led_activity
);

    localparam int CNT_W = (ACT_HOLD > 1) ? $clog2(ACT_HOLD) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(ACT_HOLD - 1);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

    logic       tck_s2;
    logic       tck_s3;
    logic       tms_s;
    logic       tdi_s;
    logic       tck_rise;
    tap_state_t tap_next;

    logic [IR_LEN-1:0] ir_shift;
    logic [CNT_W-1:0]  hold_cnt;

    jtag_sync2 u_sync_tck (.clk(int_osc), .rst(rst), .d(tck), .q(tck_s2));
    jtag_sync2 u_sync_tms (.clk(int_osc), .rst(rst), .d(tms), .q(tms_s));
    jtag_sync2 u_sync_tdi (.clk(int_osc), .rst(rst), .d(tdi), .q(tdi_s));

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tap_next = next_tap(tap_state, tms_s);

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            tck_s3       <= 1'b0;
            tap_state    <= TAP_TLR;
            ir_shift     <= '0;
            ir_value     <= IR_RESET;
            ir_valid     <= 1'b0;
            dr_bit_count <= '0;
        end else begin
            tck_s3 <= tck_s2;
            if (tck_rise) begin
                tap_state <= tap_next;

                // LSB leaves first, so TDI enters at the MSB; the exit edge to Ex1IR still shifts.
                if (tap_state == TAP_SHIR) begin
                    ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
                end else if (tap_state == TAP_CAPIR) begin
                    ir_shift <= IR_CAPTURE;
                end

                if (tap_next == TAP_TLR) begin
                    ir_value <= IR_RESET;
                    ir_valid <= 1'b0;
                end else if (tap_next == TAP_UPDIR) begin
                    ir_value <= ir_shift;
                    ir_valid <= 1'b1;
                end

                if (tap_next == TAP_CAPDR) begin
                    dr_bit_count <= '0;
                end else if (tap_state == TAP_SHDR && dr_bit_count != 16'hFFFF) begin
                    dr_bit_count <= dr_bit_count + 16'd1;
                end
            end
        end
    end

`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
    logic        tdo_s;
    logic [31:0] dr_shift;

    jtag_sync2 u_sync_tdo (.clk(int_osc), .rst(rst), .d(tdo), .q(tdo_s));

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            dr_shift <= '0;
            dr_tdo   <= '0;
        end else if (tck_rise) begin
            if (tap_state == TAP_SHDR) begin
                dr_shift <= {tdo_s, dr_shift[31:1]};
            end
            if (tap_next == TAP_UPDDR) begin
                dr_tdo <= dr_shift;
            end
        end
    end
`else
    logic unused_tdo;
    assign unused_tdo = tdo;
`endif

    always_ff @(posedge int_osc or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (tck_rise) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Including the rise cycle itself makes one TCK edge light the LED for ACT_HOLD cycles.
    assign led_activity = tck_rise | (hold_cnt != '0);

endmodule

// File: tb/tb_jtag_tap_monitor.sv
// Self-checking bench for jtag_tap_monitor: random TCK/TMS/TDI/TDO traffic against a table-driven TAP model.
module tb_jtag_tap_monitor;

    localparam int         IR_LEN   = 4;
    localparam logic [3:0] IR_RST   = 4'h1;
    localparam int         ACT_HOLD = 10;
    localparam int         EXP_W    = 25;

    logic        int_osc;
    logic        rst;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic [3:0]  tap_state;
    logic [3:0]  ir_value;
    logic        ir_valid;
    logic [15:0] dr_bit_count;
`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
    logic [31:0] dr_tdo;
`endif
    logic        led_activity;

    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    bit track = 1'b0;

    // Reference model: transition tables (nibble i = successor of state i) and bit histories.
    logic [63:0] nxt0_tbl = 64'hCACCBABA62CE3232;
    logic [63:0] nxt1_tbl = 64'hF97789DD417F0155;
    logic [3:0]  m_state;
    logic [3:0]  m_ir_val;
    logic        m_ir_valid;
    int          m_cnt;
    bit          ir_hist[$];
    bit          dr_hist[$];
    logic [31:0] m_dr_tdo;

    jtag_tap_monitor #(
        .IR_LEN  (IR_LEN),
        .IR_RESET(IR_RST),
        .ACT_HOLD(ACT_HOLD)
    ) dut (
        .int_osc     (int_osc),
        .rst         (rst),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tap_state   (tap_state),
        .ir_value    (ir_value),
        .ir_valid    (ir_valid),
        .dr_bit_count(dr_bit_count),
`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
        .dr_tdo      (dr_tdo),
`endif
        .led_activity(led_activity)
    );

    // Clock and reset
    initial begin
        int_osc = 1'b0;
        forever #5 int_osc = ~int_osc;
    end

    initial begin
        rst = 1'b1;
        tck = 1'b0;
        tms = 1'b0;
        tdi = 1'b0;
        tdo = 1'b0;
    end

    function automatic void model_reset();
        m_state    = 4'hF;
        m_ir_val   = IR_RST;
        m_ir_valid = 1'b0;
        m_cnt      = 0;
        m_dr_tdo   = '0;
        ir_hist.delete();
        dr_hist.delete();
        for (int i = 0; i < IR_LEN; i++) ir_hist.push_back(1'b0);
        for (int i = 0; i < 32; i++) dr_hist.push_back(1'b0);
    endfunction

    function automatic void model_step(input logic tms_v, input logic tdi_v, input logic tdo_v);
        logic [3:0] cur;
        logic [3:0] nxt;
        cur = m_state;
        nxt = tms_v ? nxt1_tbl[int'(cur)*4 +: 4] : nxt0_tbl[int'(cur)*4 +: 4];
        if (cur == 4'hE) begin
            for (int i = 0; i < IR_LEN; i++) ir_hist.push_back(i == 0);
        end
        if (cur == 4'hA) ir_hist.push_back(tdi_v);
        if (cur == 4'h2) begin
            dr_hist.push_back(tdo_v);
            if (m_cnt < 65535) m_cnt++;
        end
        if (nxt == 4'h6) m_cnt = 0;
        if (nxt == 4'hD) begin
            for (int i = 0; i < IR_LEN; i++) m_ir_val[i] = ir_hist[ir_hist.size() - IR_LEN + i];
            m_ir_valid = 1'b1;
        end
        if (nxt == 4'h5) begin
            for (int j = 0; j < 32; j++) m_dr_tdo[31-j] = dr_hist[dr_hist.size() - 1 - j];
        end
        if (nxt == 4'hF) begin
            m_ir_val   = IR_RST;
            m_ir_valid = 1'b0;
        end
        m_state = nxt;
        while (ir_hist.size() > 64) void'(ir_hist.pop_front());
        while (dr_hist.size() > 64) void'(dr_hist.pop_front());
        exp_q.push_back({m_state, m_ir_valid, m_ir_val, m_cnt[15:0]});
    endfunction

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge int_osc);
            #1;
        end
    endtask

    task automatic tck_step(input logic tms_v, input logic tdi_v, input logic tdo_v, input int half);
        tck = 1'b0;
        tms = tms_v;
        tdi = tdi_v;
        tdo = tdo_v;
        wait_cyc(half);
        tck = 1'b1;
        model_step(tms_v, tdi_v, tdo_v);
        wait_cyc(half);
    endtask

    task automatic settle();
        wait_cyc(5);
    endtask

    // Scoreboard: each tracked TCK rise is compared three int_osc cycles later
    initial begin
        logic             prev;
        logic [3:0]       pipe;
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] got;
        prev = 1'b0;
        pipe = '0;
        forever begin
            @(negedge int_osc);
            pipe = {pipe[2:0], (track && !rst && tck && !prev)};
            prev = tck;
            if (pipe[3]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_underflow: observed a TCK step, required none pending");
                end else begin
                    e   = exp_q.pop_front();
                    got = {tap_state, ir_valid, ir_value, dr_bit_count};
                    if (got !== e) begin
                        n_errors++;
                        $display("FAIL scoreboard: got st=%h valid=%b ir=%h cnt=%0d, required st=%h valid=%b ir=%h cnt=%0d",
                                 got[24:21], got[20], got[19:16], got[15:0], e[24:21], e[20], e[19:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        track = 1'b0;
        rst   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tck = ~tck;
            tms = 1'($urandom_range(0, 1));
            wait_cyc(2);
        end
        tck = 1'b0;
        wait_cyc(4);
        n_checks++;
        if (tap_state !== 4'hF) begin n_errors++; $display("FAIL reset_state: got %h, required f", tap_state); end
        n_checks++;
        if (ir_value !== IR_RST) begin n_errors++; $display("FAIL reset_ir: got %h, required %h", ir_value, IR_RST); end
        n_checks++;
        if (ir_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ir_valid: got %b, required 0", ir_valid); end
        n_checks++;
        if (led_activity !== 1'b0) begin n_errors++; $display("FAIL reset_led: got %b, required 0", led_activity); end
        n_checks++;
        if (dr_bit_count !== 16'd0) begin n_errors++; $display("FAIL reset_count: got %0d, required 0", dr_bit_count); end
`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
        n_checks++;
        if (dr_tdo !== 32'd0) begin n_errors++; $display("FAIL reset_dr_tdo: got %h, required 0", dr_tdo); end
`endif
        rst = 1'b0;
        model_reset();
        wait_cyc(2);
        track = 1'b1;
    endtask

    task automatic test_navigation();
        logic       nav_tms[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] nav_exp[5] = '{4'hC, 4'h7, 4'h4, 4'hE, 4'hA};
        for (int i = 0; i < 5; i++) begin
            tck_step(nav_tms[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3);
            settle();
            n_checks++;
            if (tap_state !== nav_exp[i]) begin
                n_errors++;
                $display("FAIL nav_step%0d: got %h, required %h", i, tap_state, nav_exp[i]);
            end
        end
    endtask

    task automatic test_ir_scan();
        logic bits[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) tck_step(i == 3, bits[i], 1'($urandom_range(0, 1)), 3);
        tck_step(1'b1, 1'b0, 1'b0, 3);
        settle();
        n_checks++;
        if (ir_value !== 4'h9) begin n_errors++; $display("FAIL ir_scan_value: got %h, required 9", ir_value); end
        n_checks++;
        if (ir_valid !== 1'b1) begin n_errors++; $display("FAIL ir_scan_valid: got %b, required 1", ir_valid); end
        n_checks++;
        if (tap_state !== 4'hD) begin n_errors++; $display("FAIL ir_scan_state: got %h, required d", tap_state); end
    endtask

    task automatic test_dr_scan();
        logic [31:0] data;
        data = 32'hDEADBEEF;
        tck_step(1'b1, 1'b0, 1'b0, 2);
        tck_step(1'b0, 1'b0, 1'b0, 2);
        tck_step(1'b0, 1'b0, 1'b0, 2);
        for (int k = 0; k < 32; k++) tck_step(k == 31, 1'($urandom_range(0, 1)), data[k], 2);
        tck_step(1'b1, 1'b0, 1'b0, 2);
        settle();
        n_checks++;
        if (dr_bit_count !== 16'd32) begin n_errors++; $display("FAIL dr_scan_count: got %0d, required 32", dr_bit_count); end
        n_checks++;
        if (tap_state !== 4'h5) begin n_errors++; $display("FAIL dr_scan_state: got %h, required 5", tap_state); end
`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
        n_checks++;
        if (dr_tdo !== 32'hDEADBEEF) begin n_errors++; $display("FAIL dr_scan_tdo: got %h, required deadbeef", dr_tdo); end
`endif
    endtask

    task automatic test_escape();
        int n;
        n = $urandom_range(3, 20);
        tck_step(1'b1, 1'b0, 1'b0, 2);
        tck_step(1'b0, 1'b0, 1'b0, 2);
        tck_step(1'b0, 1'b0, 1'b0, 2);
        for (int i = 0; i < n; i++) tck_step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
        for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 2);
        settle();
        n_checks++;
        if (tap_state !== 4'hF) begin n_errors++; $display("FAIL escape_state: got %h, required f", tap_state); end
        n_checks++;
        if (ir_value !== IR_RST) begin n_errors++; $display("FAIL escape_ir: got %h, required %h", ir_value, IR_RST); end
        n_checks++;
        if (ir_valid !== 1'b0) begin n_errors++; $display("FAIL escape_ir_valid: got %b, required 0", ir_valid); end
        n_checks++;
        if (dr_bit_count !== 16'(n + 1)) begin n_errors++; $display("FAIL escape_count: got %0d, required %0d", dr_bit_count, n + 1); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            tck_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2);
        end
        settle();
        n_checks++;
        if (tap_state !== m_state) begin n_errors++; $display("FAIL b2b_state: got %h, required %h", tap_state, m_state); end
        n_checks++;
        if (dr_bit_count !== 16'(m_cnt)) begin n_errors++; $display("FAIL b2b_count: got %0d, required %0d", dr_bit_count, m_cnt); end
        n_checks++;
        if (ir_value !== m_ir_val) begin n_errors++; $display("FAIL b2b_ir: got %h, required %h", ir_value, m_ir_val); end
`ifdef JTAG_TAP_MON_TDO_CAPTURE_EN
        n_checks++;
        if (dr_tdo !== m_dr_tdo) begin n_errors++; $display("FAIL b2b_dr_tdo: got %h, required %h", dr_tdo, m_dr_tdo); end
`endif
    endtask

    task automatic test_rst_midscan();
        logic [3:0] v;
        logic       nav[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++) tck_step(nav[i], 1'b0, 1'b0, 3);
        tck_step(1'b0, 1'b1, 1'b0, 3);
        tck_step(1'b0, 1'b1, 1'b0, 3);
        tck = 1'b0;
        settle();
        rst = 1'b1;
        wait_cyc(1);
        n_checks++;
        if (tap_state !== 4'hF) begin n_errors++; $display("FAIL midrst_state: got %h, required f", tap_state); end
        n_checks++;
        if (ir_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_ir_valid: got %b, required 0", ir_valid); end
        n_checks++;
        if (ir_value !== IR_RST) begin n_errors++; $display("FAIL midrst_ir: got %h, required %h", ir_value, IR_RST); end
        rst = 1'b0;
        model_reset();
        wait_cyc(3);
        v = 4'($urandom_range(0, 15));
        for (int i = 0; i < 5; i++) tck_step(nav[i], 1'b0, 1'b0, 3);
        for (int i = 0; i < 4; i++) tck_step(i == 3, v[i], 1'b0, 3);
        tck_step(1'b1, 1'b0, 1'b0, 3);
        settle();
        n_checks++;
        if (ir_value !== v) begin n_errors++; $display("FAIL midrst_rescan_ir: got %h, required %h", ir_value, v); end
        n_checks++;
        if (ir_valid !== 1'b1) begin n_errors++; $display("FAIL midrst_rescan_valid: got %b, required 1", ir_valid); end
    endtask

    task automatic test_activity();
        int highs;
        tck = 1'b0;
        tms = 1'b0;
        wait_cyc(ACT_HOLD + 10);
        n_checks++;
        if (led_activity !== 1'b0) begin n_errors++; $display("FAIL act_idle: got %b, required 0", led_activity); end

        highs = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin tck = 1'b1; model_step(1'b0, tdi, tdo); end
            if (c == 3) tck = 1'b0;
            wait_cyc(1);
            if (led_activity === 1'b1) highs++;
        end
        n_checks++;
        if (highs != ACT_HOLD) begin n_errors++; $display("FAIL act_single: got %0d high cycles, required %0d", highs, ACT_HOLD); end

        highs = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0 || c == 5) begin tck = 1'b1; model_step(1'b0, tdi, tdo); end
            if (c == 2 || c == 8) tck = 1'b0;
            wait_cyc(1);
            if (led_activity === 1'b1) highs++;
        end
        n_checks++;
        if (highs != ACT_HOLD + 5) begin n_errors++; $display("FAIL act_retrigger: got %0d high cycles, required %0d", highs, ACT_HOLD + 5); end
    endtask

    initial begin
        wait_cyc(2);
        test_reset();
        test_navigation();
        test_ir_scan();
        test_dr_scan();
        test_escape();
        test_back_to_back();
        test_rst_midscan();
        test_activity();
        settle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending steps, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
